// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. It issues sequential fetches into
//             a synchronous-read instruction memory, keeps one fetch in
//             flight, and buffers returned {pc, inst} pairs in a small
//             prefetch FIFO that feeds decode through a valid/ready handshake.
//             A taken branch (branch_alu & branch_control) flushes everything
//             and restarts fetching at br_pc.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              PC_W       = 11,
  parameter int              INST_W     = 32,
  parameter int              IMEM_DEPTH = 32,
  parameter int              BUF_DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_alu,
  input  logic              branch_control,
  input  logic [PC_W-1:0]   br_pc,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [INST_W-1:0] imem_wdata,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  // Pointer width for the power-of-two prefetch FIFO; count needs one more
  // bit so that a completely full buffer is representable.
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int MEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  // Addresses at or above MEM_LIMIT are outside the memory and read as NOP.
  localparam logic [PC_W:0]      MEM_LIMIT = (PC_W + 1)'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0]   BUF_FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PC_W-1:0]    PC_ONE    = PC_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              fl_valid_q, fl_valid_d;   // in-flight tag valid
  logic [PC_W-1:0]   fl_pc_q,    fl_pc_d;      // in-flight tag pc
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [INST_W-1:0] rdata_q,    rdata_d;      // memory read register

  logic [INST_W-1:0] imem     [IMEM_DEPTH];
  logic [PC_W-1:0]   buf_pc   [BUF_DEPTH];
  logic [INST_W-1:0] buf_inst [BUF_DEPTH];

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic              redirect;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [CNT_W-1:0]  occupancy;

  // Handshake, redirect and issue decisions for the current cycle.
  always_comb begin
    redirect    = branch_alu & branch_control;
    fifo_empty  = (count_q == '0);
    pop         = ~fifo_empty & inst_ready;
    // The in-flight slot counts against the buffer so its data always has
    // room to land, which is what keeps the FIFO from ever overflowing.
    occupancy   = count_q + {{PTR_W{1'b0}}, fl_valid_q};
    issue       = ~redirect & (occupancy < BUF_FULL);
    // A redirect throws the returning instruction away instead of pushing it.
    push        = fl_valid_q & ~redirect;
    rd_in_range = ({1'b0, fetch_pc_q} < MEM_LIMIT);
    wr_in_range = ({1'b0, imem_waddr} < MEM_LIMIT);
  end

  // Next fetch address and in-flight tag.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fl_valid_d = 1'b0;
    fl_pc_d    = fl_pc_q;
    if (redirect) begin
      fetch_pc_d = br_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_ONE;
      fl_valid_d = 1'b1;
      fl_pc_d    = fetch_pc_q;
    end
  end

  // Next FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Memory read data; out-of-range addresses fetch an all-zero NOP.
  always_comb begin
    rdata_d = '0;
    if (rd_in_range) begin
      rdata_d = imem[fetch_pc_q[MEM_AW-1:0]];
    end
  end

  // Control registers, cleared asynchronously so a reset drops all work at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      fl_valid_q <= 1'b0;
      fl_pc_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fl_valid_q <= fl_valid_d;
      fl_pc_q    <= fl_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Synchronous read port, captured only when a fetch issues so the data
  // stays put until the in-flight entry is pushed on the following edge.
  always_ff @(posedge clk) begin
    if (issue) begin
      rdata_q <= rdata_d;
    end
  end

  // Write port; contents survive reset, and a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (imem_we && wr_in_range) begin
      imem[imem_waddr[MEM_AW-1:0]] <= imem_wdata;
    end
  end

  // FIFO storage write for the returning in-flight fetch.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr_q]   <= fl_pc_q;
      buf_inst[wr_ptr_q] <= rdata_q;
    end
  end

  // Head of the FIFO drives decode; zeros whenever the buffer is empty,
  // which also covers the reset state.
  always_comb begin
    inst_valid = ~fifo_empty;
    inst       = '0;
    pc         = '0;
    if (!fifo_empty) begin
      inst = buf_inst[rd_ptr_q];
      pc   = buf_pc[rd_ptr_q];
    end
  end

endmodule
`default_nettype wire
